// File: rtl/tinytea_pkg.sv
// Shared definitions for the tinyenc / tinydec pair: config register offsets,
// 16-bit half and 32-bit word types, the key record and the round counter width.
// No logic lives here; both endpoints import it so their register maps stay identical.
package tinytea_pkg;

    // Config register byte offsets
    localparam logic [31:0] ADDR_KEY10  = 32'h0000_0000;
    localparam logic [31:0] ADDR_KEY32  = 32'h0000_0004;
    localparam logic [31:0] ADDR_DELTA  = 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;

    // Round counter must hold N = 16 (SHIFT = 4)
    localparam int ROUND_CNT_W = 5;

    typedef logic [15:0]            half_t;
    typedef logic [31:0]            word_t;
    typedef logic [ROUND_CNT_W-1:0] cnt_t;

    // Key as packed so that {k3,k2,k1,k0} maps straight onto a 64-bit literal
    typedef struct packed {
        half_t k3;
        half_t k2;
        half_t k1;
        half_t k0;
    } key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Data words are packed {y,x}: y in the upper half, x in the lower half
    function automatic word_t join_halves(input half_t y, input half_t x);
        return {y, x};
    endfunction

endpackage

// File: rtl/tinytea_f.sv
// Purpose: combinational TEA-style round mixing function on 16-bit halves.
// Latency: 0 cycles (pure combinational).  Backpressure: none, no state.
// Ports: v = value mixed, ka/kb = key halves, s = running sum, f = F(v,ka,kb,s).
module tinytea_f
    import tinytea_pkg::*;
(
    input  logic [15:0] v,
    input  logic [15:0] ka,
    input  logic [15:0] kb,
    input  logic [15:0] s,
    output logic [15:0] f
);

    half_t term_hi;
    half_t term_mid;
    half_t term_lo;

    // All three terms wrap at 16 bits; the right shift is logical.
    assign term_hi  = half_t'(v << 4) + ka;
    assign term_mid = v + s;
    assign term_lo  = (v >> 5) + kb;
    assign f        = term_hi ^ term_mid ^ term_lo;

endmodule

// File: rtl/tinydec.sv
// Purpose: iterative 16-bit-half TEA-style decryptor, receive side of the tinyenc link.
// Latency: N = 1<<SHIFT cycles from accepted req to ack=1 with rdata valid.
// Backpressure: req is only accepted while ack=1; config accesses stall (pready=0) while busy.
// Ports: clk/rst (async, active-high); req/wdata = start + ciphertext {y,x};
//        ack/rdata = idle flag + plaintext {y,x}; psel/penable/pwrite/paddr/pwdata/prdata/pready
//        = APB-style config port for {k1,k0} @0x0, {k3,k2} @0x4, delta @0x8, status @0xC.
module tinydec
    import tinytea_pkg::*;
#(
    parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
    parameter logic [15:0] DELTA = 16'h1,
    parameter int          SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready
);

    localparam cnt_t NROUNDS = cnt_t'(1 << SHIFT);

    state_t state_q, state_d;
    cnt_t   cnt_q,   cnt_d;
    half_t  x_q,     x_d;
    half_t  y_q,     y_d;
    half_t  sum_q,   sum_d;
    word_t  rdata_q, rdata_d;

    // Programmable key/delta as seen by the config port
    key_t   key_q,   key_d;
    half_t  delta_q, delta_d;

    // Copy taken at start: a config write landing on the start edge must not
    // leak into the operation that starts on that same edge.
    key_t   run_key_q,   run_key_d;
    half_t  run_delta_q, run_delta_d;

    half_t  f_y;
    half_t  f_x;
    half_t  y_new;
    half_t  x_new;
    logic   cfg_wr;

    assign ack    = (cnt_q == '0);
    assign pready = ack;
    assign rdata  = rdata_q;
    assign cfg_wr = psel & penable & pwrite & pready;

    // Undo the encryptor's last step first: y was updated last, using the final x.
    tinytea_f u_f_y (
        .v  (x_q),
        .ka (run_key_q.k2),
        .kb (run_key_q.k3),
        .s  (sum_q),
        .f  (f_y)
    );

    assign y_new = y_q - f_y;

    // x is then recovered with the freshly restored y.
    tinytea_f u_f_x (
        .v  (y_new),
        .ka (run_key_q.k0),
        .kb (run_key_q.k1),
        .s  (sum_q),
        .f  (f_x)
    );

    assign x_new = x_q - f_x;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sum_q       <= '0;
            rdata_q     <= '0;
            key_q       <= key_t'(KEY);
            delta_q     <= DELTA;
            run_key_q   <= key_t'(KEY);
            run_delta_q <= DELTA;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_q       <= sum_d;
            rdata_q     <= rdata_d;
            key_q       <= key_d;
            delta_q     <= delta_d;
            run_key_q   <= run_key_d;
            run_delta_q <= run_delta_d;
        end
    end

    // ------------------------------------------------------------------
    // Round sequencer and datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_d       = sum_q;
        rdata_d     = rdata_q;
        run_key_d   = run_key_q;
        run_delta_d = run_delta_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_RUN;
                    cnt_d       = NROUNDS;
                    x_d         = wdata[15:0];
                    y_d         = wdata[31:16];
                    // Encryptor ends with sum = N*delta; start from there and walk back.
                    sum_d       = half_t'(delta_q << SHIFT);
                    run_key_d   = key_q;
                    run_delta_d = delta_q;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - cnt_t'(1);
                x_d   = x_new;
                y_d   = y_new;
                sum_d = sum_q - run_delta_q;
                if (cnt_q == cnt_t'(1)) begin
                    state_d = ST_IDLE;
                    rdata_d = join_halves(y_new, x_new);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config register file
    // ------------------------------------------------------------------
    always_comb begin
        key_d   = key_q;
        delta_d = delta_q;
        if (cfg_wr) begin
            case (paddr)
                ADDR_KEY10: begin
                    key_d.k1 = pwdata[31:16];
                    key_d.k0 = pwdata[15:0];
                end
                ADDR_KEY32: begin
                    key_d.k3 = pwdata[31:16];
                    key_d.k2 = pwdata[15:0];
                end
                ADDR_DELTA: begin
                    delta_d = pwdata[15:0];
                end
                default: begin
                    // status is read-only, other offsets are unmapped
                end
            endcase
        end
    end

    always_comb begin
        prdata = '0;
        case (paddr)
            ADDR_KEY10:  prdata = {key_q.k1, key_q.k0};
            ADDR_KEY32:  prdata = {key_q.k3, key_q.k2};
            ADDR_DELTA:  prdata = {16'h0000, delta_q};
            ADDR_STATUS: prdata = {31'h0, ~ack};
            default:     prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_tinydec.sv
// Directed bench for tinydec: register-read and round-trip tables plus hand-written
// multi-cycle sequences (config while busy, same-edge start/write, back-to-back, reset mid-run).
// Ciphertexts come from a local behavioural encryptor; the DUT must return the plaintext.
module tb_tinydec;

    localparam logic [63:0] DEF_KEY   = 64'h816fc52b09e74da3;
    localparam logic [15:0] DEF_DELTA = 16'h1;
    localparam int          NR        = 8;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] cur_key;
    logic [15:0] cur_delta;

    tinydec dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] pt;
        int          exp_busy;
    } rt_vec_t;

    rd_vec_t rd_tab [5];
    rt_vec_t rt_tab [6];

    // ---------------- behavioural encryptor ----------------
    function automatic logic [15:0] tf(input logic [15:0] v, input logic [15:0] ka,
                                       input logic [15:0] kb, input logic [15:0] s);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        a = (v << 4) + ka;
        b = v + s;
        c = (v >> 5) + kb;
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] pt, input logic [63:0] k,
                                        input logic [15:0] d);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        x = pt[15:0];
        y = pt[31:16];
        s = 16'h0;
        for (int r = 0; r < NR; r++) begin
            s = s + d;
            x = x + tf(y, k[15:0], k[31:16], s);
            y = y + tf(x, k[47:32], k[63:48], s);
        end
        return {y, x};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: no ack/pready within cycle budget", name);
    endtask

    // Count edges until ack returns, bounded.
    task automatic wait_ack(input string name, output int n);
        n = 0;
        while (!ack && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ack) timeout_fail(name);
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pready) timeout_fail("apb_write");
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pready) timeout_fail("apb_read");
        d = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic decrypt(input logic [31:0] ct, output logic [31:0] pt, output int busy);
        req = 1'b1; wdata = ct;
        @(posedge clk); #1;
        req = 1'b0;
        wait_ack("decrypt", busy);
        pt = rdata;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] res;
        logic [31:0] pt;
        logic [31:0] ct;
        logic [31:0] prev;
        logic [31:0] bb_pt [3];
        logic [31:0] bb_ct [3];
        int          busy;
        int          n;

        rst = 1'b1; req = 1'b0; wdata = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        cur_key = DEF_KEY; cur_delta = DEF_DELTA;

        rd_tab[0] = '{32'h0000_0000, 32'h09e74da3};
        rd_tab[1] = '{32'h0000_0004, 32'h816fc52b};
        rd_tab[2] = '{32'h0000_0008, 32'h0000_0001};
        rd_tab[3] = '{32'h0000_000C, 32'h0000_0000};
        rd_tab[4] = '{32'h0000_0010, 32'h0000_0000};

        rt_tab[0] = '{32'h12345678, NR};
        rt_tab[1] = '{32'h00000000, NR};
        rt_tab[2] = '{32'hFFFFFFFF, NR};
        rt_tab[3] = '{32'h80000001, NR};
        rt_tab[4] = '{32'h0000FFFF, NR};
        rt_tab[5] = '{32'hFFFF0000, NR};

        // 1. Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack", 32'(ack), 32'h1);
        chk("rst_pready", 32'(pready), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            apb_read(rd_tab[i].addr, rd);
            chk($sformatf("rst_read_%0h", rd_tab[i].addr), rd, rd_tab[i].exp);
        end

        // 2. Round trips with default parameters
        for (int i = 0; i < 6; i++) begin
            ct = enc(rt_tab[i].pt, cur_key, cur_delta);
            decrypt(ct, res, busy);
            chk($sformatf("rt_data_%0d", i), res, rt_tab[i].pt);
            chk($sformatf("rt_busy_%0d", i), 32'(busy), 32'(rt_tab[i].exp_busy));
        end
        for (int i = 0; i < 200; i++) begin
            pt = $urandom;
            ct = enc(pt, cur_key, cur_delta);
            decrypt(ct, res, busy);
            chk("rand_rt", res, pt);
        end

        // 3. Zero key and delta
        apb_write(32'h0, 32'h0);
        apb_write(32'h4, 32'h0);
        apb_write(32'h8, 32'h0);
        cur_key = 64'h0; cur_delta = 16'h0;
        for (int i = 0; i < 3; i++) begin
            apb_read(rd_tab[i].addr, rd);
            chk("zero_readback", rd, 32'h0);
        end
        decrypt(32'h0, res, busy);
        chk("zero_dec0", res, 32'h0);
        decrypt(32'hDEADBEEF, res, busy);
        chk("zero_deadbeef", enc(res, cur_key, cur_delta), 32'hDEADBEEF);

        // Restore defaults through the port; delta write checks the upper-half mask
        apb_write(32'h0, DEF_KEY[31:0]);
        apb_write(32'h4, DEF_KEY[63:32]);
        apb_write(32'h8, 32'hABCD0001);
        cur_key = DEF_KEY; cur_delta = DEF_DELTA;
        apb_read(32'h8, rd);
        chk("delta_mask", rd, 32'h0000_0001);
        apb_write(32'h10, 32'h5555_5555);
        apb_read(32'h10, rd);
        chk("unmapped_read", rd, 32'h0);

        // 4. Config write while busy
        prev = rdata;
        pt = 32'hCAFEF00D;
        ct = enc(pt, cur_key, cur_delta);
        req = 1'b1; wdata = ct;
        @(posedge clk); #1;
        req = 1'b0;
        chk("busy_ack", 32'(ack), 32'h0);
        psel = 1'b1; pwrite = 1'b0; paddr = 32'hC;
        #1;
        chk("status_busy", prdata, 32'h1);
        chk("pready_busy", 32'(pready), 32'h0);
        chk("rdata_hold", rdata, prev);
        pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h11112222; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        wait_ack("cfg_busy", n);
        chk("cfg_wait_cycles", 32'(n), 32'd7);
        chk("cfg_busy_oldkey", rdata, pt);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        cur_key[31:0] = 32'h11112222;
        apb_read(32'h0, rd);
        chk("cfg_busy_newkey", rd, 32'h11112222);

        // Start and config write on the same edge: operation keeps the old key
        pt = 32'h0BADC0DE;
        ct = enc(pt, cur_key, cur_delta);
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h33334444; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; req = 1'b1; wdata = ct;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; req = 1'b0;
        chk("same_edge_ack", 32'(ack), 32'h0);
        wait_ack("same_edge", n);
        chk("same_edge_busy", 32'(n), 32'(NR));
        chk("same_edge_data", rdata, pt);
        cur_key[63:32] = 32'h33334444;
        apb_read(32'h4, rd);
        chk("same_edge_key", rd, 32'h33334444);

        // 5. Back-to-back with req held high
        bb_pt[0] = 32'hA5A5A5A5;
        bb_pt[1] = 32'h5A5A0F0F;
        bb_pt[2] = 32'h13579BDF;
        for (int k = 0; k < 3; k++) bb_ct[k] = enc(bb_pt[k], cur_key, cur_delta);
        req = 1'b1; wdata = bb_ct[0];
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) wdata = bb_ct[k+1];
            else req = 1'b0;
            wait_ack("b2b", n);
            chk($sformatf("b2b_busy_%0d", k), 32'(n), 32'(NR));
            chk($sformatf("b2b_data_%0d", k), rdata, bb_pt[k]);
            if (k < 2) begin
                @(posedge clk); #1;
                chk($sformatf("b2b_restart_%0d", k), 32'(ack), 32'h0);
            end
        end

        // Pulse on req mid-run is ignored
        pt = 32'h2468ACE0;
        ct = enc(pt, cur_key, cur_delta);
        req = 1'b1; wdata = ct;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b1; wdata = 32'hFFFF0000;
        @(posedge clk); #1;
        n++;
        req = 1'b0;
        while (!ack && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ack) timeout_fail("pulse");
        chk("pulse_busy", 32'(n), 32'(NR));
        chk("pulse_data", rdata, pt);
        @(posedge clk); #1;
        chk("pulse_no_queue", 32'(ack), 32'h1);

        // 6. Reset in the middle of an operation
        pt = 32'h600DF00D;
        ct = enc(pt, cur_key, cur_delta);
        req = 1'b1; wdata = ct;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy", 32'(ack), 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack), 32'h1);
        chk("midrst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_key = DEF_KEY; cur_delta = DEF_DELTA;
        for (int i = 0; i < 3; i++) begin
            apb_read(rd_tab[i].addr, rd);
            chk($sformatf("midrst_read_%0h", rd_tab[i].addr), rd, rd_tab[i].exp);
        end
        ct = enc(pt, cur_key, cur_delta);
        decrypt(ct, res, busy);
        chk("midrst_next_data", res, pt);
        chk("midrst_next_busy", 32'(busy), 32'(NR));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
